// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// RISC-V load/store funct3 encodings, byte-lane mask and alignment helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    // Byte lanes touched by an access of 2**size bytes starting at lane off.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic r;
        case (size)
            2'd1:    r = off[0];
            2'd2:    r = |off[1:0];
            2'd3:    r = |off;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment: extracts and sign/zero-extends load data from a
// 64-bit word, and positions store data with its byte-lane write mask.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] rword,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [7:0]  store_mask,
    output logic [63:0] store_data
);

    logic [5:0]  shamt;
    logic [63:0] shifted;

    assign shamt   = {offset, 3'b000};
    assign shifted = rword >> shamt;

    always_comb begin
        load_data = shifted;
        case (funct3[1:0])
            2'b00: load_data = funct3[2] ? {56'b0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = funct3[2] ? {48'b0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
            2'b10: load_data = funct3[2] ? {32'b0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // High bytes of wdata land in lanes the mask leaves untouched.
    assign store_mask = lane_mask(funct3[1:0], offset);
    assign store_data = wdata << shamt;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for MEM-stage load/store traffic with fixed access latency.
// Optional perf counters (load/store/error) under DATA_MEM_RESPONDER_PERF_CNT_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
    ,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
    output logic [31:0] err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_INIT = cnt_t'(LATENCY - 1);

    dmem_state_e state, next_state;
    cnt_t        cnt;

    logic        lat_write;
    logic [2:0]  lat_funct3;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;

    logic        accept;
    logic        enter_resp;
    logic        acc_write;
    logic [2:0]  acc_funct3;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic        acc_err;
    logic [AW-1:0] idx;
    logic [63:0] rword;
    logic [63:0] load_data;
    logic [7:0]  store_mask;
    logic [63:0] store_data;
    logic        mem_we;

    logic [63:0] mem [DEPTH_WORDS];

    assign accept = req_valid & req_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (LATENCY > 1) ? WAIT : RESP;
            WAIT: if (cnt == '0) next_state = RESP;
            RESP: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // ---------------- access datapath ----------------
    // With LATENCY==1 the access happens on the acceptance edge, so the live
    // request fields are used instead of the latched copy.
    assign acc_write  = (state == IDLE) ? req_write  : lat_write;
    assign acc_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
    assign acc_addr   = (state == IDLE) ? req_addr   : lat_addr;
    assign acc_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

    assign enter_resp = (state != RESP) && (next_state == RESP);

    assign acc_err = (acc_funct3 == F3_BAD)
                   | (acc_write & acc_funct3[2])
                   | misaligned(acc_funct3[1:0], acc_addr[2:0])
                   | (|acc_addr[63:AW+3]);

    assign idx   = acc_addr[3 +: AW];
    assign rword = mem[idx];

    dmem_lane_align u_align (
        .funct3     (acc_funct3),
        .offset     (acc_addr[2:0]),
        .rword      (rword),
        .wdata      (acc_wdata),
        .load_data  (load_data),
        .store_mask (store_mask),
        .store_data (store_data)
    );

    assign mem_we = enter_resp & acc_write & ~acc_err;

    // Storage is deliberately not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (store_mask[b]) mem[idx][b*8 +: 8] <= store_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_funct3 <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                lat_write  <= req_write;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                cnt        <= CNT_INIT;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_resp) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err | acc_write) ? 64'd0 : load_data;
            end
        end
    end

`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else if (enter_resp) begin
            if (acc_err)        err_cnt   <= sat_inc(err_cnt);
            else if (acc_write) store_cnt <= sat_inc(store_cnt);
            else                load_cnt  <= sat_inc(load_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=64).
// Also checks the perf counters when DATA_MEM_RESPONDER_PERF_CNT_EN is defined.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
    logic [31:0] load_cnt, store_cnt, err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
        ,
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; checks latency and handshake.
    task automatic xfer(input string tag, input logic w, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er);
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, 64'(lat), 64'(LAT));
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
        chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] exp, input logic exp_err);
        logic [63:0] rd;
        logic er;
        xfer(tag, 1'b0, f3, a, 64'd0, rd, er);
        chk({tag, "_rdata"}, rd, exp);
        chk({tag, "_err"}, 64'(er), 64'(exp_err));
    endtask

    task automatic st(input string tag, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, input logic exp_err);
        logic [63:0] rd;
        logic er;
        xfer(tag, 1'b1, f3, a, wd, rd, er);
        chk({tag, "_rdata"}, rd, 64'd0);
        chk({tag, "_err"}, 64'(er), 64'(exp_err));
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #3;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err",   64'(rsp_err), 64'd0);
        @(negedge clk); reset = 1'b1;

        // Basic double store/load
        st("sd10", F3_D, 64'h10, 64'h1122334455667788, 1'b0);
        ld("ld10", F3_D, 64'h10, 64'h1122334455667788, 1'b0);

        // Byte / half / word extension
        st("sd0",  F3_D,  64'h0, 64'h80FF_0000_0000_7F80, 1'b0);
        ld("lb0",  F3_B,  64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        ld("lbu0", F3_BU, 64'h0, 64'h0000_0000_0000_0080, 1'b0);
        ld("lh6",  F3_H,  64'h6, 64'hFFFF_FFFF_FFFF_80FF, 1'b0);
        ld("lhu6", F3_HU, 64'h6, 64'h0000_0000_0000_80FF, 1'b0);

        // Partial store keeps other lanes
        st("sb1",  F3_B,  64'h1, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
        ld("ld0a", F3_D,  64'h0, 64'h80FF_0000_0000_AB80, 1'b0);

        // Error cases, then confirm memory untouched
        ld("lw2_mis",   F3_W,   64'h2,   64'd0, 1'b1);
        ld("ld200_oor", F3_D,   64'h200, 64'd0, 1'b1);
        st("sd_f3bad",  F3_BAD, 64'h0,   64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        st("sbu_bad",   F3_BU,  64'h0,   64'h0000_0000_0000_00FF, 1'b1);
        ld("ld0b", F3_D,  64'h0, 64'h80FF_0000_0000_AB80, 1'b0);
        ld("lw4",  F3_W,  64'h4, 64'hFFFF_FFFF_80FF_0000, 1'b0);
        ld("lwu4", F3_WU, 64'h4, 64'h0000_0000_80FF_0000, 1'b0);

        // Backpressure: response held 5 cycles, next request waits with req_valid high
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_D; req_addr = 64'h10;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 64'h0;  // changed while not ready: must not affect the pending access
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_rdata", rsp_rdata, 64'h1122334455667788);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(rsp_valid), 64'd0);
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_next_accepted", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_next_valid", 64'(rsp_valid), 64'd1);
        chk("bp_next_rdata", rsp_rdata, 64'h80FF_0000_0000_AB80);
        @(posedge clk); #1;

        // Reset during WAIT drops the pending store
        st("sd8_prior", F3_D, 64'h8, 64'h0123_4567_89AB_CDEF, 1'b0);
`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
        chk("cnt_load",  64'(load_cnt),  64'd11);
        chk("cnt_store", 64'(store_cnt), 64'd4);
        chk("cnt_err",   64'(err_cnt),   64'd4);
`endif
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_D; req_addr = 64'h8;
        req_wdata = 64'h0000_0000_0000_DEAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_req_ready", 64'(req_ready), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 64'd0);
`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
        chk("midrst_load_cnt", 64'(load_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        ld("ld8_after_rst", F3_D, 64'h8, 64'h0123_4567_89AB_CDEF, 1'b0);
`ifdef DATA_MEM_RESPONDER_PERF_CNT_EN
        chk("final_load_cnt",  64'(load_cnt),  64'd1);
        chk("final_store_cnt", 64'(store_cnt), 64'd0);
        chk("final_err_cnt",   64'(err_cnt),   64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
